// File: rtl/nadajnik_wyjsc_pkg.sv
// Shared constants for the serial output stage: frame width, bit counter
// width and FSM state encodings.
package nadajnik_wyjsc_pkg;

  localparam int RAMKA_W = 64;
  localparam int BIT_W   = 6;

  localparam logic [2:0] S_BEZCZYNNY = 3'd0;
  localparam logic [2:0] S_NISKI     = 3'd1;
  localparam logic [2:0] S_WYSOKI    = 3'd2;
  localparam logic [2:0] S_ZATRZASK  = 3'd3;
  localparam logic [2:0] S_KONIEC    = 3'd4;

  typedef enum logic [2:0] {
    BEZCZYNNY = S_BEZCZYNNY,
    NISKI     = S_NISKI,
    WYSOKI    = S_WYSOKI,
    ZATRZASK  = S_ZATRZASK,
    KONIEC    = S_KONIEC
  } stan_t;

endpackage

// File: rtl/nadajnik_wyjsc_rejestr_przesuwny.sv
// Parallel-load, shift-left register; load wins over shift, zeros (or si)
// enter at bit 0.
module rejestr_przesuwny #(
  parameter int W = 64
) (
  input  logic         zegar,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         load,
  input  logic         si,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge zegar or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
    else if (ce)   q <= {q[W-2:0], si};
  end

endmodule

// File: rtl/nadajnik_wyjsc.sv
// Serial output stage: snapshots Q0..Q7 and shifts the 64-bit frame MSB
// first into an external 74HC595 chain, then strobes rclk.
module nadajnik_wyjsc
  import nadajnik_wyjsc_pkg::*;
#(
  parameter int DZIELNIK = 4
) (
  input  logic       zegar,
  input  logic       rst_n,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic [7:0] in6,
  input  logic [7:0] in7,
  input  logic       start,
  output logic       sck,
  output logic       sdo,
  output logic       rclk,
  output logic       zajety,
  output logic       gotowe
);

  localparam int DZ_W = (DZIELNIK > 1) ? $clog2(DZIELNIK) : 1;
  localparam logic [DZ_W-1:0] DZ_MAX = DZ_W'(DZIELNIK - 1);

  generate
    if (DZIELNIK < 1) begin : g_zly_dzielnik
      $error("nadajnik_wyjsc: DZIELNIK must be >= 1");
    end
  endgenerate

  stan_t              stan, nast;
  logic [DZ_W-1:0]    licz_dz;
  logic [BIT_W-1:0]   licz_bit;
  logic [RAMKA_W-1:0] ostatnio;
  logic [RAMKA_W-1:0] ramka;
  logic [RAMKA_W-1:0] migawka;
  logic               pierwszy;
  logic               oczekuje;
  logic               wyzwol;
  logic               dz_koniec;
  logic               laduj;
  logic               przesun;

  assign ramka     = {in7, in6, in5, in4, in3, in2, in1, in0};
  assign wyzwol    = start | oczekuje | pierwszy | (ramka != ostatnio);
  assign dz_koniec = (licz_dz == DZ_MAX);

  always_ff @(posedge zegar or negedge rst_n) begin
    if (!rst_n) stan <= BEZCZYNNY;
    else        stan <= nast;
  end

  always_comb begin
    nast    = stan;
    laduj   = 1'b0;
    przesun = 1'b0;
    case (stan)
      BEZCZYNNY: if (wyzwol) begin
        nast  = NISKI;
        laduj = 1'b1;
      end
      NISKI:     if (dz_koniec) nast = WYSOKI;
      WYSOKI:    if (dz_koniec) begin
        przesun = 1'b1;
        nast    = (licz_bit == '0) ? ZATRZASK : NISKI;
      end
      ZATRZASK:  if (dz_koniec) nast = KONIEC;
      KONIEC:    nast = BEZCZYNNY;
      default:   nast = BEZCZYNNY;
    endcase
  end

  // Divider restarts at every phase boundary so each phase lasts DZIELNIK cycles.
  always_ff @(posedge zegar or negedge rst_n) begin
    if (!rst_n) begin
      licz_dz <= '0;
    end else if (stan == NISKI || stan == WYSOKI || stan == ZATRZASK) begin
      licz_dz <= dz_koniec ? '0 : licz_dz + 1'b1;
    end else begin
      licz_dz <= '0;
    end
  end

  always_ff @(posedge zegar or negedge rst_n) begin
    if (!rst_n) begin
      licz_bit <= '0;
      ostatnio <= '0;
      pierwszy <= 1'b1;
      oczekuje <= 1'b0;
    end else begin
      if (laduj) begin
        licz_bit <= BIT_W'(RAMKA_W - 1);
        ostatnio <= ramka;
        pierwszy <= 1'b0;
        oczekuje <= 1'b0;
      end else begin
        if (przesun) licz_bit <= licz_bit - 1'b1;
        if (start && stan != BEZCZYNNY) oczekuje <= 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they line up with stan.
  always_ff @(posedge zegar or negedge rst_n) begin
    if (!rst_n) begin
      sck    <= 1'b0;
      rclk   <= 1'b0;
      zajety <= 1'b0;
      gotowe <= 1'b0;
    end else begin
      sck    <= (nast == WYSOKI);
      rclk   <= (nast == ZATRZASK);
      zajety <= (nast != BEZCZYNNY);
      gotowe <= (nast == KONIEC);
    end
  end

  rejestr_przesuwny #(.W(RAMKA_W)) u_migawka (
    .zegar (zegar),
    .rst_n (rst_n),
    .ce    (przesun),
    .load  (laduj),
    .si    (1'b0),
    .d     (ramka),
    .q     (migawka)
  );

  // sdo is the snapshot MSB; it only moves on load or on the sck fall.
  assign sdo = migawka[RAMKA_W-1];

endmodule

// File: tb/tb_nadajnik_wyjsc.sv
// Bench: 74HC595 chain model plus a queue of expected frames derived from
// the input values the bench applies.
module tb_nadajnik_wyjsc;

  localparam int DZ  = 4;
  localparam int LEN = 129 * DZ + 1;

  logic        zegar = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] drv   = '0;
  logic        sck, sdo, rclk, zajety, gotowe;

  always #5 zegar = ~zegar;

  nadajnik_wyjsc #(.DZIELNIK(DZ)) dut (
    .zegar (zegar), .rst_n (rst_n),
    .in0 (drv[7:0]),   .in1 (drv[15:8]),  .in2 (drv[23:16]), .in3 (drv[31:24]),
    .in4 (drv[39:32]), .in5 (drv[47:40]), .in6 (drv[55:48]), .in7 (drv[63:56]),
    .start (start), .sck (sck), .sdo (sdo), .rclk (rclk),
    .zajety (zajety), .gotowe (gotowe)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] chain, latched, e_mon;
  int nbits = 0, busy_run = 0, idle_run = 0, last_gap = 0, rclk_run = 0;
  int frames = 0, sck_rises = 0, busy_total = 0;
  logic p_sck = 0, p_sdo = 0, p_rclk = 0, p_got = 0, p_zaj = 0;

  // Chain model and protocol monitor, sampled on the falling edge.
  always @(negedge zegar) begin
    if (!rst_n) begin
      nbits = 0; busy_run = 0; rclk_run = 0;
      p_sck = 0; p_sdo = 0; p_rclk = 0; p_got = 0; p_zaj = 0;
    end else begin
      if (zajety) begin
        if (!p_zaj) begin last_gap = idle_run; idle_run = 0; end
        busy_run++; busy_total++;
      end else begin
        busy_run = 0; idle_run++;
      end
      chk("overlap", {63'd0, sck & rclk}, 64'd0);
      if (sck && p_sck) chk("sdo_hold", {63'd0, sdo}, {63'd0, p_sdo});
      if (sck && !p_sck) begin
        if (nbits == 0) chk("first_rise", busy_run, DZ + 1);
        chain = {chain[62:0], sdo};
        nbits++; sck_rises++;
      end
      if (rclk) rclk_run++;
      if (rclk && !p_rclk) begin
        chk("nbits", nbits, 64);
        latched = chain;
        if (exp_q.size() != 0) e_mon = exp_q.pop_front();
        else                   e_mon = 'x;
        chk("frame", latched, e_mon);
        nbits = 0;
      end
      if (!rclk && p_rclk) begin
        chk("rclk_len", rclk_run, DZ);
        rclk_run = 0;
      end
      if (gotowe) begin
        chk("gotowe_pulse", {63'd0, p_got}, 64'd0);
        chk("gotowe_at", busy_run, LEN);
        frames++;
      end
      p_sck = sck; p_sdo = sdo; p_rclk = rclk; p_got = gotowe; p_zaj = zajety;
    end
  end

  task automatic wait_frames(input int target, input int lim);
    for (int i = 0; i < lim && frames < target; i++) @(negedge zegar);
    if (frames < target) chk("timeout", frames, target);
  endtask

  task automatic wait_busy(input int n, input int lim);
    for (int i = 0; i < lim && busy_run < n; i++) @(negedge zegar);
    if (busy_run < n) chk("busy_timeout", busy_run, n);
  endtask

  task automatic drive(input logic [63:0] v);
    @(posedge zegar); #1 drv = v;
  endtask

  task automatic pulse_start();
    @(posedge zegar); #1 start = 1'b1;
    @(posedge zegar); #1 start = 1'b0;
  endtask

  initial begin
    int f, s0, b0;
    logic [63:0] v, x, y;
    repeat (3) @(negedge zegar);
    chk("rst_sck", {63'd0, sck}, 64'd0);
    chk("rst_sdo", {63'd0, sdo}, 64'd0);
    chk("rst_rclk", {63'd0, rclk}, 64'd0);
    chk("rst_zajety", {63'd0, zajety}, 64'd0);
    chk("rst_gotowe", {63'd0, gotowe}, 64'd0);

    // Forced post-reset frame of zeros, then a long quiet period.
    exp_q.push_back(64'd0);
    @(posedge zegar); #1 rst_n = 1'b1;
    wait_frames(1, 700);
    @(negedge zegar);
    s0 = sck_rises; b0 = busy_total;
    repeat (2000) @(negedge zegar);
    chk("quiet_sck", sck_rises - s0, 0);
    chk("quiet_busy", busy_total - b0, 0);

    // in7 = A5 lands in the top byte of the chain.
    v = {8'hA5, 56'd0};
    exp_q.push_back(v);
    drive(v);
    wait_frames(2, 700);
    chk("a5_byte", {56'd0, latched[63:56]}, 64'h00000000000000A5);

    // Random frames, plus start-forced repeats of unchanged data.
    f = 2;
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 2) begin
        exp_q.push_back(v);
        pulse_start();
      end else begin
        v = {$urandom, $urandom};
        exp_q.push_back(v);
        drive(v);
      end
      f++;
      wait_frames(f, 700);
    end

    // Input change mid-frame: old value first, new value after one idle cycle.
    x = {$urandom, $urandom};
    y = ~x;
    exp_q.push_back(x);
    drive(x);
    wait_busy(100, 300);
    exp_q.push_back(y);
    drive(y);
    f += 2;
    wait_frames(f, 1400);
    chk("gap", last_gap, 1);

    // Two start pulses during a frame give exactly one extra frame.
    v = {$urandom, $urandom};
    exp_q.push_back(v);
    drive(v);
    wait_busy(50, 200);
    pulse_start();
    wait_busy(200, 300);
    pulse_start();
    exp_q.push_back(v);
    f += 2;
    wait_frames(f, 1400);
    repeat (1500) @(negedge zegar);
    chk("one_extra", frames, f);

    // Reset mid-frame: outputs drop at once, full frame resent afterwards.
    v = {$urandom, $urandom};
    exp_q.push_back(v);
    drive(v);
    for (int i = 0; i < 400 && nbits < 34; i++) @(negedge zegar);
    chk("reached_bit30", nbits, 34);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sck", {63'd0, sck}, 64'd0);
    chk("arst_sdo", {63'd0, sdo}, 64'd0);
    chk("arst_rclk", {63'd0, rclk}, 64'd0);
    chk("arst_zajety", {63'd0, zajety}, 64'd0);
    repeat (3) @(posedge zegar);
    #1 rst_n = 1'b1;
    f++;
    wait_frames(f, 700);
    repeat (5) @(negedge zegar);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nadajnik_wyjsc.md
# nadajnik_wyjsc

Serial output stage downstream of the processor's output register bank. It snapshots the eight output bytes Q0..Q7 and shifts all 64 bits into an external chain of 74HC595-style shift registers. It generates the shift clock, serial data and latch strobe, and retransmits automatically whenever any output byte changes. Only latched, complete frames ever reach the physical PLC outputs.

## Interface
- DZIELNIK, 4: half-period of sck in zegar cycles; legal range ≥1; 0 is rejected at elaboration.
- zegar  in  1  system clock; all flops on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in0..in7  in  8 each  output bytes from the processor output register (Q0..Q7).
- start  in  1  forces one transfer even if the data is unchanged; single-cycle pulse or level.
- sck  out  1  serial shift clock to the external chain; registered.
- sdo  out  1  serial data; registered; changes only while sck=0.
- rclk  out  1  latch strobe to the external chain; registered.
- zajety  out  1  transfer in progress.
- gotowe  out  1  one-cycle pulse when a frame has been latched.

## Operation
- Registers:
  - migawka[63:0]: snapshot shift register.
  - ostatnio[63:0]: last frame sent.
  - licz_bit: 6-bit bit counter.
  - licz_dz: divider counter.
  - pierwszy: forces the post-reset transfer.
  - oczekuje: remembers a start request.
- Frame bit order: {in7,...,in0}, MSB first. in7[7] is shifted first and in0[0] last, so in0[0] lands in stage 0 of the chain.
- FSM states: BEZCZYNNY, NISKI, WYSOKI, ZATRZASK, KONIEC.
- BEZCZYNNY:
  - Trigger condition: start | oczekuje | pierwszy | ({in7..in0} != ostatnio).
  - On trigger: migawka and ostatnio ← {in7..in0}; clear pierwszy and oczekuje; licz_bit=63; sdo ← bit 63; go to NISKI.
- NISKI: sck=0 for DZIELNIK cycles, then go to WYSOKI.
- WYSOKI:
  - sck=1 for DZIELNIK cycles. The external chain samples sdo on the sck rising edge.
  - On exit, sck returns to 0 and migawka shifts left; sdo takes the next bit in the same cycle.
  - licz_bit decrements. After bit 0, go to ZATRZASK instead of NISKI.
- ZATRZASK: rclk=1 and sck=0 for DZIELNIK cycles, then go to KONIEC.
- KONIEC: gotowe=1 for one cycle, then go to BEZCZYNNY.
- Input changes during a transfer do not alter the frame in flight. They are detected by the comparison on the next BEZCZYNNY cycle.
- A start during zajety sets oczekuje. That transfer is serviced right after KONIEC.
- zajety=1 in every state except BEZCZYNNY.

## Timing
- Reset values:
  - Outputs: sck=0, sdo=0, rclk=0, zajety=0, gotowe=0.
  - Internal: state=BEZCZYNNY, ostatnio=0, oczekuje=0, pierwszy=1.
- Reset mid-transfer: abort immediately; all outputs go to 0 asynchronously; rclk is never pulsed for a partial frame. After release, pierwszy forces a full transfer.
- Trigger sampled at edge k: zajety=1 and sdo=bit63 after edge k. First sck rise after edge k+DZIELNIK.
- Frame duration: zajety is high for 128·DZIELNIK + DZIELNIK + 1 cycles. With DZIELNIK=4 this is 517 cycles.
- Gap between frames: minimum 1 BEZCZYNNY cycle (zajety=0).
- sdo setup to the sck rise is DZIELNIK cycles; hold is ≥ DZIELNIK cycles.
- rclk never overlaps sck=1.
- DZIELNIK=1 gives an sck period of 2 zegar cycles, and the frame takes 130 cycles.

## Structure
- Shared include file:
  - State encodings for BEZCZYNNY..KONIEC as localparams.
  - The frame width constant 64.
- Sub-module rejestr_przesuwny: 64-bit parallel-load, shift-left register with ce and load inputs. It is reusable for a future serial input stage.
- The divider counter and FSM live in nadajnik_wyjsc itself.

## Test plan
- Reset release with all inputs 0, DZIELNIK=4 → one forced frame of 64 zeros; rclk high for 4 cycles; gotowe pulses at cycle 517; then the block stays idle.
- in7=8'hA5, other bytes 0 → a bench shift-register model shows in7=A5 after rclk; sdo sequence starts 1,0,1,0,0,1,0,1.
- Inputs static and no start for 2000 cycles after a frame → no sck edges and zajety=0.
- Change in0 at cycle 100 of a transfer → the current frame carries the old value; a second frame follows after 1 idle cycle with the new value.
- start pulsed twice during a transfer → exactly one extra frame afterwards.
- rst_n asserted at bit 30 → sck, sdo and rclk drop to 0 at once; no rclk pulse; a full frame is sent after release.
